// File: rtl/fpga_ram_pkg.sv
// Shared types and helpers for the dual-port FPGA RAM.
// Read-during-write modes, FSM states and byte-lane sizing.
package fpga_ram_pkg;

  typedef enum logic {
    RD_WRITE_FIRST = 1'b0,
    RD_READ_FIRST  = 1'b1
  } rdmode_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int nbytes(input int dw, input int bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/fpga_ram_dp_if.sv
// Port bundle of the dual-port RAM: port A read/write,
// port B read-only, plus the init-done flag.
interface fpga_ram_dp_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10,
  parameter int BYTEWIDTH = 8
);
  import fpga_ram_pkg::*;

  localparam int NBYTES = nbytes(DATAWIDTH, BYTEWIDTH);

  logic [ADDRWIDTH-1:0] PortAAddr;
  logic [DATAWIDTH-1:0] PortADataIn;
  logic [NBYTES-1:0]    PortAWriteEnable;
  logic                 PortAReadEnable;
  logic [DATAWIDTH-1:0] PortADataOut;
  logic                 PortADataValid;
  logic [ADDRWIDTH-1:0] PortBAddr;
  logic                 PortBReadEnable;
  logic [DATAWIDTH-1:0] PortBDataOut;
  logic                 PortBDataValid;
  logic                 InitDone;

  modport master (
    output PortAAddr, PortADataIn, PortAWriteEnable,
    output PortAReadEnable, PortBAddr, PortBReadEnable,
    input  PortADataOut, PortADataValid,
    input  PortBDataOut, PortBDataValid, InitDone
  );

  modport slave (
    input  PortAAddr, PortADataIn, PortAWriteEnable,
    input  PortAReadEnable, PortBAddr, PortBReadEnable,
    output PortADataOut, PortADataValid,
    output PortBDataOut, PortBDataValid, InitDone
  );

endinterface

// File: rtl/fpga_ram_outstage.sv
// Optional output register for one RAM port; a plain
// wire-through when OUTREG is 0.
module fpga_ram_outstage #(
  parameter int DATAWIDTH = 32,
  parameter bit OUTREG    = 1'b0
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic [DATAWIDTH-1:0] raw_data,
  input  logic                 raw_valid,
  output logic [DATAWIDTH-1:0] data,
  output logic                 valid
);

  if (OUTREG) begin : g_reg
    always_ff @(posedge Clk) begin
      if (!RstN) begin
        data  <= '0;
        valid <= 1'b0;
      end else begin
        valid <= raw_valid;
        if (raw_valid) data <= raw_data;
      end
    end
  end else begin : g_bypass
    assign data  = raw_data;
    assign valid = raw_valid;
  end

endmodule

// File: rtl/fpga_ram_dp.sv
// Simple dual-port block RAM: byte-write port A with selectable
// read-during-write, read-only port B, post-reset zero sweep.
module fpga_ram_dp #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10,
  parameter int BYTEWIDTH = 8,
  parameter int RDMODE    = 0,
  parameter bit OUTREG    = 1'b0,
  parameter bit INITCLEAR = 1'b1
) (
  input logic          Clk,
  input logic          RstN,
  fpga_ram_dp_if.slave bus
);
  import fpga_ram_pkg::*;

  localparam int NBYTES   = nbytes(DATAWIDTH, BYTEWIDTH);
  localparam int MEMDEPTH = 2 ** ADDRWIDTH;

  if (DATAWIDTH % BYTEWIDTH != 0) begin : g_chk
    $fatal(1, "DATAWIDTH must be a multiple of BYTEWIDTH");
  end

  state_e               state;
  state_e               state_nxt;
  logic [ADDRWIDTH-1:0] cnt;
  logic [ADDRWIDTH-1:0] cnt_nxt;
  logic                 clr;
  logic                 run;

  logic [DATAWIDTH-1:0] mem [MEMDEPTH];
  logic [DATAWIDTH-1:0] old_a;
  logic [DATAWIDTH-1:0] merged;
  logic                 acc_a;
  logic                 wr_a;
  logic                 rd_b;
  logic [DATAWIDTH-1:0] a_raw;
  logic                 a_raw_v;
  logic [DATAWIDTH-1:0] b_raw;
  logic                 b_raw_v;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      INIT: begin
        cnt_nxt = cnt + ADDRWIDTH'(1);
        if (!INITCLEAR || cnt == '1) state_nxt = RUN;
      end
      RUN: state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Reset edges must leave memory untouched, hence the RstN gating.
  always_comb begin
    clr = 1'b0;
    run = 1'b0;
    unique case (state)
      INIT: clr = RstN & INITCLEAR;
      RUN:  run = RstN;
      default: ;
    endcase
  end

  assign bus.InitDone = (state == RUN);

  assign wr_a  = run & (|bus.PortAWriteEnable);
  assign acc_a = run & (bus.PortAReadEnable | (|bus.PortAWriteEnable));
  assign rd_b  = run & bus.PortBReadEnable;
  assign old_a = mem[bus.PortAAddr];

  always_comb begin
    merged = old_a;
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.PortAWriteEnable[i])
        merged[i*BYTEWIDTH +: BYTEWIDTH] =
          bus.PortADataIn[i*BYTEWIDTH +: BYTEWIDTH];
    end
  end

  always_ff @(posedge Clk) begin
    if (clr) mem[cnt] <= '0;
    else if (wr_a) mem[bus.PortAAddr] <= merged;
  end

  // Port B samples the pre-write word on an address collision.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      a_raw   <= '0;
      a_raw_v <= 1'b0;
      b_raw   <= '0;
      b_raw_v <= 1'b0;
    end else begin
      a_raw_v <= acc_a;
      b_raw_v <= rd_b;
      if (acc_a)
        a_raw <= (RDMODE == int'(RD_READ_FIRST)) ? old_a : merged;
      if (rd_b) b_raw <= mem[bus.PortBAddr];
    end
  end

  fpga_ram_outstage #(
    .DATAWIDTH(DATAWIDTH),
    .OUTREG   (OUTREG)
  ) u_out_a (
    .Clk      (Clk),
    .RstN     (RstN),
    .raw_data (a_raw),
    .raw_valid(a_raw_v),
    .data     (bus.PortADataOut),
    .valid    (bus.PortADataValid)
  );

  fpga_ram_outstage #(
    .DATAWIDTH(DATAWIDTH),
    .OUTREG   (OUTREG)
  ) u_out_b (
    .Clk      (Clk),
    .RstN     (RstN),
    .raw_data (b_raw),
    .raw_valid(b_raw_v),
    .data     (bus.PortBDataOut),
    .valid    (bus.PortBDataValid)
  );

endmodule

// File: tb/tb_fpga_ram_dp.sv
// Bench for fpga_ram_dp: write-first/no-outreg and
// read-first/outreg instances against one reference model.
module tb_fpga_ram_dp;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic Clk = 1'b0;
  logic RstN = 1'b0;
  always #5 Clk = ~Clk;

  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic [3:0]    a_we;
  logic          a_re;
  logic [AW-1:0] b_addr;
  logic          b_re;

  fpga_ram_dp_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8)) bus0 ();
  fpga_ram_dp_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8)) bus1 ();

  assign bus0.PortAAddr = a_addr;
  assign bus0.PortADataIn = a_din;
  assign bus0.PortAWriteEnable = a_we;
  assign bus0.PortAReadEnable = a_re;
  assign bus0.PortBAddr = b_addr;
  assign bus0.PortBReadEnable = b_re;
  assign bus1.PortAAddr = a_addr;
  assign bus1.PortADataIn = a_din;
  assign bus1.PortAWriteEnable = a_we;
  assign bus1.PortAReadEnable = a_re;
  assign bus1.PortBAddr = b_addr;
  assign bus1.PortBReadEnable = b_re;

  fpga_ram_dp #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8),
    .RDMODE(0), .OUTREG(1'b0), .INITCLEAR(1'b1)
  ) dut0 (.Clk(Clk), .RstN(RstN), .bus(bus0));

  fpga_ram_dp #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8),
    .RDMODE(1), .OUTREG(1'b1), .INITCLEAR(1'b1)
  ) dut1 (.Clk(Clk), .RstN(RstN), .bus(bus1));

  // Reference model: memory, edges since reset release, and the
  // expected port outputs of each instance.
  logic [DW-1:0] mem [DEPTH];
  int swept;
  logic [DW-1:0] e0a_d, e0b_d, e1a_d, e1b_d, p1a_d, p1b_d;
  logic e0a_v, e0b_v, e1a_v, e1b_v, p1a_v, p1b_v;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic [3:0] we, input logic re,
                        input logic [AW-1:0] ba, input logic br);
    a_addr = aa; a_din = ad; a_we = we; a_re = re;
    b_addr = ba; b_re = br;
  endtask

  task automatic idle();
    set_in('0, '0, 4'h0, 1'b0, '0, 1'b0);
  endtask

  task automatic rand_in();
    set_in(AW'($urandom_range(0, DEPTH-1)), $urandom,
           ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
           1'($urandom), AW'($urandom_range(0, DEPTH-1)), 1'($urandom));
  endtask

  task automatic tick();
    logic [DW-1:0] old_a, new_a, old_b;
    logic acc, rb;
    old_a = '0; new_a = '0; old_b = '0;
    acc = 1'b0; rb = 1'b0;
    @(posedge Clk);
    #1;
    if (!RstN) begin
      swept = 0;
      e0a_d = '0; e0b_d = '0; e1a_d = '0; e1b_d = '0;
      e0a_v = 0; e0b_v = 0; e1a_v = 0; e1b_v = 0;
      p1a_v = 0; p1b_v = 0; p1a_d = '0; p1b_d = '0;
    end else begin
      if (swept < DEPTH) begin
        mem[swept] = '0;
        swept++;
      end else begin
        acc = a_re || (a_we != 4'h0);
        rb = b_re;
        old_a = mem[a_addr];
        old_b = mem[b_addr];
        new_a = old_a;
        for (int i = 0; i < 4; i++)
          if (a_we[i]) new_a[8*i +: 8] = a_din[8*i +: 8];
        if (a_we != 4'h0) mem[a_addr] = new_a;
      end
      e1a_v = p1a_v;
      if (p1a_v) e1a_d = p1a_d;
      e1b_v = p1b_v;
      if (p1b_v) e1b_d = p1b_d;
      p1a_v = acc;
      if (acc) p1a_d = old_a;
      p1b_v = rb;
      if (rb) p1b_d = old_b;
      e0a_v = acc;
      if (acc) e0a_d = new_a;
      e0b_v = rb;
      if (rb) e0b_d = old_b;
    end
    chk("done0", 32'(bus0.InitDone), 32'(swept >= DEPTH));
    chk("done1", 32'(bus1.InitDone), 32'(swept >= DEPTH));
    chk("a0_v", 32'(bus0.PortADataValid), 32'(e0a_v));
    chk("a0_d", bus0.PortADataOut, e0a_d);
    chk("b0_v", 32'(bus0.PortBDataValid), 32'(e0b_v));
    chk("b0_d", bus0.PortBDataOut, e0b_d);
    chk("a1_v", 32'(bus1.PortADataValid), 32'(e1a_v));
    chk("a1_d", bus1.PortADataOut, e1a_d);
    chk("b1_v", 32'(bus1.PortBDataValid), 32'(e1b_v));
    chk("b1_d", bus1.PortBDataOut, e1b_d);
  endtask

  initial begin
    idle();
    RstN = 1'b0;
    tick();
    tick();

    // Sweep with noise on the inputs; it must all be ignored.
    RstN = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_in();
      a_we = 4'hf;
      tick();
    end
    chk("sweep_done", 32'(bus0.InitDone), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      set_in(AW'(i), '0, 4'h0, 1'b1, AW'(DEPTH-1-i), 1'b1);
      tick();
    end
    idle();
    tick();
    tick();

    set_in(AW'(3), 32'h1122_3344, 4'hf, 1'b0, '0, 1'b0);
    tick();
    set_in(AW'(3), 32'hAABB_CCDD, 4'b0101, 1'b0, '0, 1'b0);
    tick();
    chk("merge_wf", bus0.PortADataOut, 32'h11BB_33DD);
    set_in(AW'(3), '0, 4'h0, 1'b1, '0, 1'b0);
    tick();
    chk("merge_rf", bus1.PortADataOut, 32'h1122_3344);
    idle();
    tick();
    chk("reread_rf", bus1.PortADataOut, 32'h11BB_33DD);
    chk("pulse_a0", 32'(bus0.PortADataValid), 32'd0);

    set_in(AW'(5), 32'hDEAD_BEEF, 4'hf, 1'b0, AW'(5), 1'b1);
    tick();
    chk("coll_b0", bus0.PortBDataOut, 32'h0);
    set_in('0, '0, 4'h0, 1'b0, AW'(5), 1'b1);
    tick();
    chk("after_b0", bus0.PortBDataOut, 32'hDEAD_BEEF);
    chk("coll_b1", bus1.PortBDataOut, 32'h0);
    idle();
    tick();
    chk("after_b1", bus1.PortBDataOut, 32'hDEAD_BEEF);

    for (int i = 0; i < 200; i++) begin
      rand_in();
      tick();
    end

    // Reset pulse in the middle of a fresh sweep.
    idle();
    RstN = 1'b0;
    tick();
    RstN = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    RstN = 1'b0;
    tick();
    RstN = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      rand_in();
      tick();
    end
    chk("mid_done0", 32'(bus0.InitDone), 32'd0);
    idle();
    tick();
    chk("mid_done1", 32'(bus1.InitDone), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      set_in(AW'(i), '0, 4'h0, 1'b1, AW'(i), 1'b1);
      tick();
    end
    for (int i = 0; i < 60; i++) begin
      rand_in();
      tick();
    end
    idle();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
